fetch_buffer: RTL and testbench

//  Fetch-side instruction queue between the PC/instruction-memory stage and decode.

---
 rtl/fetch_buffer.sv | 107 ++++++++++
 tb/tb_fetch_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch-side instruction queue between the PC/instruction-memory stage and decode.
// Holds {instr, PC, PC+4} in a circular buffer; in_ready doubles as the PC-register enable.
module fetch_buffer #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       instr_in,
  input  logic [WIDTH-1:0]       pc_in,
  input  logic [WIDTH-1:0]       pcplus4_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       instr_d,
  output logic [WIDTH-1:0]       pc_d,
  output logic [WIDTH-1:0]       pcplus4_d,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 3 * WIDTH;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends on occupancy only, so a full queue never passes through on a pop.
  assign in_ready  = ~full;
  assign out_valid = ~empty;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {instr_in, pc_in, pcplus4_in};
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    instr_d   = NOP;
    pc_d      = '0;
    pcplus4_d = '0;
    if (!empty) begin
      instr_d   = head[3*WIDTH-1:2*WIDTH];
      pc_d      = head[2*WIDTH-1:WIDTH];
      pcplus4_d = head[WIDTH-1:0];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: stimulus pushes accepted fetches into a reference queue, and a
// separate monitor compares every visible head/occupancy against it each cycle.
module tb_fetch_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   instr_in = '0;
  logic [31:0]   pc_in = '0;
  logic [31:0]   pcplus4_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   instr_d;
  logic [31:0]   pc_d;
  logic [31:0]   pcplus4_d;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  entry_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     pops = 0;
  int     cyc = 0;
  bit     pop_pending = 1'b0;
  bit     flush_pending = 1'b0;

  fetch_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NOP  (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .pcplus4_in(pcplus4_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pcplus4_d (pcplus4_d),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] instr);
    entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pcp4  = pc + 32'd4;
    return e;
  endfunction

  // Monitor: checks state after each edge, then retires the head when decode takes it.
  initial begin
    forever begin
      @(negedge clk);
      check("count", 32'(count), 32'(exp_q.size()));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) begin
        check("instr_d", instr_d, exp_q[0].instr);
        check("pc_d", pc_d, exp_q[0].pc);
        check("pcplus4_d", pcplus4_d, exp_q[0].pcp4);
      end else begin
        check("instr_d_empty", instr_d, NOP);
        check("pc_d_empty", pc_d, 32'h0);
        check("pcplus4_d_empty", pcplus4_d, 32'h0);
      end
      flush_pending = rst && flush;
      pop_pending   = rst && !flush && out_ready && (exp_q.size() != 0);
      @(posedge clk);
      if (flush_pending) begin
        exp_q.delete();
      end else if (pop_pending) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
  end

  // One fetch cycle: drive after the edge, record acceptance before the next edge.
  task automatic cycle(input bit iv, input entry_t e, input bit orr, input bit fl,
                       output bit acc);
    @(posedge clk);
    #1;
    cyc++;
    in_valid   = iv;
    instr_in   = e.instr;
    pc_in      = e.pc;
    pcplus4_in = e.pcp4;
    out_ready  = orr;
    flush      = fl;
    @(negedge clk);
    #1;
    acc = iv && !fl && rst && (exp_q.size() < DEPTH);
    if (acc) exp_q.push_back(e);
  endtask

  // mode: 0 = decode ready, 1 = decode stalled, 2 = stall every 3rd cycle
  task automatic send(input entry_t e, input int mode);
    bit acc;
    bit orr;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      orr = (mode == 0) || (mode == 2 && (cyc % 3) != 2);
      cycle(1'b1, e, orr, 1'b0, acc);
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: pc %h never accepted, expected acceptance", e.pc);
    end
  endtask

  task automatic idle(input int n, input bit orr);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, mk(32'h0, 32'h0), orr, 1'b0, acc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    bit          have;
    entry_t      cur;
    logic [31:0] pc;
    int          pops0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset mid-stream with two entries queued
    send(mk(32'h100, 32'h0010_0093), 1);
    send(mk(32'h104, 32'h0020_0093), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_reset_count", 32'(count), 32'd2);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_instr_d", instr_d, NOP);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("reset_hold_count", 32'(count), 32'd0);
    rst = 1'b1;

    // Streaming with decode always ready
    send(mk(32'h0, 32'h0050_0093), 0);
    send(mk(32'h4, 32'h00A0_0113), 0);
    idle(3, 1'b1);

    // Fill, hold the third fetch, then release decode
    send(mk(32'h10, 32'h0000_0001), 1);
    send(mk(32'h14, 32'h0000_0002), 1);
    cycle(1'b1, mk(32'h18, 32'h0000_0003), 1'b0, 1'b0, acc);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_count", 32'(count), 32'd2);
    cycle(1'b1, mk(32'h18, 32'h0000_0003), 1'b1, 1'b0, acc);
    check("no_passthrough_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, mk(32'h18, 32'h0000_0003), 1'b1, 1'b0, acc);
    check("held_accept_in_ready", 32'(in_ready), 32'd1);
    check("held_accept_count", 32'(count), 32'd1);
    idle(4, 1'b1);

    // Simultaneous push and pop at count 1
    send(mk(32'h20, 32'h0000_0004), 1);
    cycle(1'b1, mk(32'h24, 32'h0000_0005), 1'b1, 1'b0, acc);
    idle(1, 1'b0);
    check("simul_count", 32'(count), 32'd1);
    check("simul_head_pc", pc_d, 32'h24);
    idle(2, 1'b1);

    // Flush with a full queue and a live input
    send(mk(32'h28, 32'h0000_0006), 1);
    send(mk(32'h2C, 32'h0000_0007), 1);
    cycle(1'b1, mk(32'h30, 32'hDEAD_0013), 1'b1, 1'b1, acc);
    idle(1, 1'b0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    send(mk(32'h40, 32'h0000_0008), 1);
    idle(1, 1'b0);
    check("post_flush_head_pc", pc_d, 32'h40);
    idle(2, 1'b1);

    // Wrap-around: nine fetches with a decode stall every third cycle
    pops0 = pops;
    for (int i = 0; i < 9; i++) begin
      send(mk(32'(i * 4), {12'(i + 1), 20'h00093}), 2);
    end
    idle(6, 1'b1);
    check("wrap_pop_total", 32'(pops - pops0), 32'd9);

    // Randomized traffic with occasional redirects
    pc   = 32'h1000;
    have = 1'b0;
    cur  = mk(32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      bit iv;
      bit orr;
      bit fl;
      if (!have) begin
        cur  = mk(pc, $urandom());
        have = 1'b1;
      end
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      cycle(iv, cur, orr, fl, acc);
      if (fl) begin
        pc   = {$urandom_range(0, 16'hFFFF), 2'b00} + 32'h2000;
        have = 1'b0;
      end else if (acc) begin
        pc   = pc + 32'd4;
        have = 1'b0;
      end
    end
    idle(5, 1'b1);
    check("final_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
